// File: rtl/alu_op_sequencer.sv
// Issue/control FSM in front of a combinational 16-bit ALU: accepts one instruction per
// handshake, fetches operands, drives the ALU, writes the result back and keeps status flags.
module alu_op_sequencer #(
   parameter int unsigned DATA_W   = 16,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [3:0]        rf_raddr1,
   output logic [3:0]        rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rf_we,
   output logic [3:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              flag_zero,
   output logic              flag_less,
   output logic              illegal,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

   localparam logic [3:0] OpAddi = 4'd9;

   state_e      state;
   logic [3:0]  opcode;
   logic [3:0]  rd;

   logic              op_legal;
   logic              op_addi;
   logic [DATA_W-1:0] imm_sx;
   logic              wb_enable;

   // rf_raddr2 doubles as the latched rt/imm4 field
   assign op_legal  = (opcode <= OpAddi);
   assign op_addi   = (opcode == OpAddi);
   assign imm_sx    = {{(DATA_W-4){rf_raddr2[3]}}, rf_raddr2};
   assign wb_enable = !(ZERO_REG && (rd == 4'd0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         opcode      <= 4'd0;
         rd          <= 4'd0;
         instr_ready <= 1'b0;
         rf_raddr1   <= 4'd0;
         rf_raddr2   <= 4'd0;
         alu_in1     <= '0;
         alu_in2     <= '0;
         alu_ctrl    <= 4'd0;
         rf_we       <= 1'b0;
         rf_waddr    <= 4'd0;
         rf_wdata    <= '0;
         flag_zero   <= 1'b0;
         flag_less   <= 1'b0;
         illegal     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         rf_we   <= 1'b0;
         illegal <= 1'b0;
         case (state)
            StIdle: begin
               if (instr_valid && instr_ready) begin
                  opcode      <= instr[15:12];
                  rd          <= instr[11:8];
                  rf_raddr1   <= instr[7:4];
                  rf_raddr2   <= instr[3:0];
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= StDecode;
               end else begin
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            StDecode: begin
               if (op_legal) begin
                  alu_in1  <= rf_rdata1;
                  alu_in2  <= op_addi ? imm_sx : rf_rdata2;
                  alu_ctrl <= op_addi ? 4'd0 : opcode;
                  state    <= StExec;
               end else begin
                  // rejected opcode: pulse illegal and reopen the handshake right away
                  illegal     <= 1'b1;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= StIdle;
               end
            end
            StExec: begin
               rf_wdata  <= alu_result;
               rf_waddr  <= rd;
               rf_we     <= wb_enable;
               flag_zero <= (alu_result == '0);
               flag_less <= alu_result[DATA_W-1];
               state     <= StWb;
            end
            StWb: begin
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               state       <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register file and ALU models around the DUT, directed cases
// followed by random instructions checked against an instruction-level reference model.
module tb_alu_op_sequencer;

   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic          instr_ready;
   logic [15:0]   instr;
   logic [3:0]    rf_raddr1, rf_raddr2;
   logic [DW-1:0] rf_rdata1, rf_rdata2;
   logic [DW-1:0] alu_in1, alu_in2, alu_result;
   logic [3:0]    alu_ctrl;
   logic          rf_we;
   logic [3:0]    rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          flag_zero, flag_less, illegal, busy;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [DW-1:0] rf   [16];
   logic [DW-1:0] mreg [16];
   logic          mzero, mless;

   logic          pre_we;
   logic [3:0]    pre_addr;
   logic [DW-1:0] pre_data;

   alu_op_sequencer #(.DATA_W(DW), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .flag_zero(flag_zero), .flag_less(flag_less), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rf_we === 1'b1) rf[rf_waddr] <= rf_wdata;
      else if (pre_we) rf[pre_addr] <= pre_data;
   end

   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   function automatic logic [DW-1:0] alu_env(input logic [3:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      case (c)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (a < b) ? DW'(1) : '0;
         4'd6: return a >> b;
         4'd7: return a << b;
         4'd8: return DW'($signed(a) >>> b);
         default: return '0;
      endcase
   endfunction

   always_comb alu_result = alu_env(alu_ctrl, alu_in1, alu_in2);

   // Instruction semantics: what rd should receive for a given opcode and operand values
   function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
      logic [DW:0] wide;
      case (op)
         4'd0, 4'd9: begin wide = {1'b0, a} + {1'b0, b}; return wide[DW-1:0]; end
         4'd1: begin wide = {1'b0, a} - {1'b0, b}; return wide[DW-1:0]; end
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (a < b) ? DW'(1) : '0;
         4'd6: return (b >= DW) ? '0 : (a >> b);
         4'd7: return (b >= DW) ? '0 : (a << b);
         4'd8: return (b >= DW) ? {DW{a[DW-1]}} : DW'($signed(a) >>> b);
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic setreg(input logic [3:0] a, input logic [DW-1:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      mreg[a]  = d;
      @(posedge clk);
      #1 pre_we = 1'b0;
      @(negedge clk);
   endtask

   // Called on a negedge; returns on a negedge with the DUT idle again
   task automatic issue(input logic [15:0] ins, input bit hold, output int acc);
      logic [3:0]    op, rd, rs, rt;
      logic [DW-1:0] a, b, res;
      bit            legal, we;
      int            waited;
      op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
      waited = 0;
      while (instr_ready !== 1'b1 && waited < 16) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait", 32'(waited < 16), 32'd1);
      instr       = ins;
      instr_valid = 1'b1;
      a     = mreg[rs];
      b     = (op == 4'd9) ? {{(DW-4){rt[3]}}, rt} : mreg[rt];
      legal = (op < 4'd10);
      res   = ref_result(op, a, b);
      we    = legal && (rd != 4'd0);
      @(posedge clk);
      #1 acc = cyc;
      if (hold) instr = 16'($urandom);
      else instr_valid = 1'b0;
      @(negedge clk);
      chk("decode_ready", instr_ready, 0);
      chk("decode_busy", busy, 1);
      chk("decode_illegal", illegal, 0);
      chk("raddr1", rf_raddr1, rs);
      chk("raddr2", rf_raddr2, rt);
      @(negedge clk);
      if (!legal) begin
         chk("illegal_pulse", illegal, 1);
         chk("illegal_we", rf_we, 0);
         chk("illegal_busy", busy, 0);
         chk("illegal_ready", instr_ready, 1);
         chk("illegal_zero", flag_zero, mzero);
         chk("illegal_less", flag_less, mless);
         return;
      end
      chk("exec_in1", alu_in1, a);
      chk("exec_in2", alu_in2, b);
      chk("exec_ctrl", alu_ctrl, (op == 4'd9) ? 4'd0 : op);
      chk("exec_we", rf_we, 0);
      if (we) mreg[rd] = res;
      mzero = (res == '0);
      mless = res[DW-1];
      @(negedge clk);
      chk("wb_we", rf_we, we);
      chk("wb_waddr", rf_waddr, rd);
      chk("wb_wdata", rf_wdata, res);
      chk("wb_zero", flag_zero, mzero);
      chk("wb_less", flag_less, mless);
      chk("wb_ready", instr_ready, 0);
      @(negedge clk);
      chk("idle_we", rf_we, 0);
      chk("idle_ready", instr_ready, 1);
      chk("idle_busy", busy, 0);
      chk("rf_commit", rf[rd], mreg[rd]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev;
      logic [3:0] op;
      rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; pre_we = 1'b0;
      pre_addr = 4'd0; pre_data = '0;
      mzero = 1'b0; mless = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", instr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_in1", alu_in1, 0);
      chk("rst_in2", alu_in2, 0);
      chk("rst_ctrl", alu_ctrl, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_flags", {flag_zero, flag_less}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", instr_ready, 1);
      for (int i = 0; i < 16; i++) setreg(4'(i), '0);

      // ADD r3 = r1 + r2
      setreg(4'd1, 16'h0005); setreg(4'd2, 16'h0003);
      issue(16'h0312, 1'b0, acc);
      chk("add_r3", rf[3], 16'h0008);
      chk("add_zero", flag_zero, 0);

      // SUB to zero
      setreg(4'd4, 16'h1234); setreg(4'd5, 16'h1234);
      issue(16'h1645, 1'b0, acc);
      chk("sub_r6", rf[6], 16'h0000);
      chk("sub_flags", {flag_zero, flag_less}, 2'b10);

      // ADDI with imm4 = -1
      setreg(4'd1, 16'h0000);
      issue(16'h921F, 1'b0, acc);
      chk("addi_in2", alu_in2, 16'hFFFF);
      chk("addi_r2", rf[2], 16'hFFFF);
      chk("addi_less", flag_less, 1);

      // Illegal opcode, then write to r0 is suppressed but flags update
      issue(16'hA123, 1'b0, acc);
      setreg(4'd0, 16'h5A5A); setreg(4'd1, 16'h0000); setreg(4'd2, 16'h0000);
      issue(16'h0012, 1'b0, acc);
      chk("r0_kept", rf[0], 16'h5A5A);
      chk("r0_flags", {flag_zero, flag_less}, 2'b10);

      // Back-to-back with instr_valid held high
      for (int k = 0; k < 6; k++) begin
         op = 4'($urandom_range(0, 9));
         prev = acc;
         issue({op, 12'($urandom)}, 1'b1, acc);
         if (k > 0) chk("throughput", 32'(acc - prev), 32'd4);
      end
      instr_valid = 1'b0;
      @(negedge clk);

      // Reset during EXEC drops the instruction
      setreg(4'd1, 16'h1111);
      instr = 16'h0312; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("exec_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstx_we", rf_we, 0);
      chk("rstx_ready", instr_ready, 0);
      chk("rstx_busy", busy, 0);
      chk("rstx_in1", alu_in1, 0);
      chk("rstx_wdata", rf_wdata, 0);
      rst = 1'b0;
      mzero = 1'b0; mless = 1'b0;
      @(negedge clk);
      chk("rstx_ready_after", instr_ready, 1);
      chk("rstx_we_after", rf_we, 0);
      chk("rstx_r3", rf[3], mreg[3]);

      // Random instructions over random register contents
      for (int i = 0; i < 16; i++) setreg(4'(i), 16'($urandom));
      for (int k = 0; k < 150; k++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if (k % 5 == 0) ins[3:0] = 4'($urandom_range(0, 3));
         issue(ins, bit'($urandom_range(0, 1)), acc);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 16; i++) chk("final_rf", rf[i], mreg[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
